// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the framed UART transmitter.
//   tx_state_e  - transmitter FSM states (PARITY exists only with UART_TX_PARITY_EN)
//   PAR_*       - parity_mode encodings (2'b11 behaves as PAR_NONE)
//   count_width - width of a FIFO occupancy count able to hold 0..depth
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } tx_state_e;
`endif

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Occupancy runs 0..depth inclusive, so one bit more than the address.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_tx_framed_if.sv
// uart_tx_framed_if: valid/ready write channel into the UART transmit buffer.
//   s_valid - write request (master -> slave)
//   s_data  - word to transmit, DATA_BITS wide (master -> slave)
//   s_ready - buffer can accept a word (slave -> master)
interface uart_tx_framed_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_BITS-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous circular FIFO buffering words for the transmitter.
//   clk, reset      - clock, synchronous active-high reset (flushes pointers/count)
//   i_push, i_data  - write strobe and word; ignored while full
//   i_pop           - remove head word; ignored while empty
//   o_data          - head word (valid while !o_empty)
//   o_count         - number of stored words
//   o_full, o_empty - registered status flags
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_push,
  input  logic [WIDTH-1:0]                i_data,
  input  logic                            i_pop,
  output logic [WIDTH-1:0]                o_data,
  output logic [count_width(DEPTH)-1:0]   o_count,
  output logic                            o_full,
  output logic                            o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = count_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;

  // Full refuses a push even when a pop happens in the same cycle.
  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Pointers, count and flags; pointers wrap naturally (power-of-2 depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;
endmodule

// File: rtl/uart_tx_framed.sv
// uart_tx_framed: buffered UART transmitter, start + data (LSB first)
// + optional parity + 1/2 stop bits. Parity support is compiled in only
// when macro UART_TX_PARITY_EN is defined; otherwise parity_mode is ignored.
//   clk, reset   - clock, synchronous active-high reset (aborts frame, flushes buffer)
//   s_if         - write channel (s_valid/s_ready/s_data), slave side
//   parity_mode  - 00 none, 01 even, 10 odd, 11 none; latched at frame start
//   tx           - serial line, idle high
//   tx_active    - high from first START cycle through last STOP cycle
//   tx_done      - one-cycle pulse in the idle cycle after a frame
//   fifo_count   - words waiting in the buffer
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 9,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  uart_tx_framed_if.slave                     s_if,
  input  logic [1:0]                          parity_mode,
  output logic                                tx,
  output logic                                tx_active,
  output logic                                tx_done,
  output logic [count_width(FIFO_DEPTH)-1:0]  fifo_count
);
  localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  tx_state_e            r_state, w_state_nxt;
  logic [CLK_W-1:0]     r_clk_cnt, w_clk_cnt_nxt;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_active, w_active_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_tick;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [DATA_BITS-1:0] w_head;
`ifdef UART_TX_PARITY_EN
  logic                 r_par_en, w_par_en_nxt;
  logic                 r_par_bit, w_par_bit_nxt;
`else
  logic                 w_unused_parity;
  assign w_unused_parity = ^parity_mode;
`endif

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (s_if.s_valid),
    .i_data  (s_if.s_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign s_if.s_ready = !w_full;

  // Last clock of the current bit period.
  assign w_tick = (r_clk_cnt == CLK_W'(CLKS_PER_BIT - 1));

  // Next-state, datapath and registered-output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = '0;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    w_done_nxt    = 1'b0;
    w_tx_nxt      = 1'b1;
`ifdef UART_TX_PARITY_EN
    w_par_en_nxt  = r_par_en;
    w_par_bit_nxt = r_par_bit;
`endif
    if (r_state != IDLE) begin
      w_clk_cnt_nxt = w_tick ? '0 : r_clk_cnt + CLK_W'(1);
    end
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = START;
`ifdef UART_TX_PARITY_EN
          w_par_en_nxt  = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
          w_par_bit_nxt = (^w_head) ^ (parity_mode == PAR_ODD);
`endif
        end
      end
      START: begin
        if (w_tick) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_tick) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt   = r_par_en ? PARITY : STOP;
`else
            w_state_nxt   = STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_tick) w_state_nxt = STOP;
      end
`endif
      STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // Line level follows the state being entered so tx lines up with it.
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_tx_nxt = w_par_bit_nxt;
`endif
      default: w_tx_nxt = 1'b1;
    endcase
    w_active_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_active  <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_active  <= w_active_nxt;
      r_done    <= w_done_nxt;
`ifdef UART_TX_PARITY_EN
      r_par_en  <= w_par_en_nxt;
      r_par_bit <= w_par_bit_nxt;
`endif
    end
  end

  assign tx        = r_tx;
  assign tx_active = r_active;
  assign tx_done   = r_done;
endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 9: clk cycles per serial bit period; legal values are 2 and above.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, range 5..9.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: TX buffer entries; must be a power of 2, 2 or more.
REQ-005 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port s_valid, input, 1 bit: write request.
REQ-008 SHALL have port s_ready, output, 1 bit: the buffer can accept a word.
REQ-009 SHALL have port s_data, input, DATA_BITS wide: word to transmit.
REQ-010 SHALL have port parity_mode, input, 2 bits: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-011 SHALL have port tx, output, 1 bit: serial line; idle level is high.
REQ-012 SHALL have port tx_active, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port tx_done, output, 1 bit: one-cycle frame-complete pulse.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of buffered words.

Function
REQ-015 SHALL accept a word on any cycle where s_valid and s_ready are both high; s_ready = (fifo_count < FIFO_DEPTH), so a push is refused while full even if a pop occurs in the same cycle.
REQ-016 SHALL allow a push and a pop in the same cycle when not full; fifo_count is then unchanged.
REQ-017 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; every non-IDLE bit lasts exactly CLKS_PER_BIT cycles.
REQ-018 In IDLE with fifo_count > 0, SHALL pop the head word into the shift register, latch parity_mode, and enter START on the next cycle.
REQ-019 SHALL drive tx low in START, data LSB-first in DATA, the parity bit in PARITY (even: XOR of data; odd: its inverse), and high in STOP for STOP_BITS bit periods.
REQ-020 SHALL skip PARITY when the latched mode is none; a parity_mode change mid-frame SHALL NOT affect the current frame.
REQ-021 SHALL hold tx_active high from the first START cycle through the last STOP cycle.
REQ-022 After the last STOP cycle, SHALL spend exactly one cycle in IDLE with tx=1 and tx_done=1, then start the next frame if the buffer is non-empty (back-to-back frames separated by one idle cycle).
REQ-023 SHALL deliver words in acceptance order, with none lost or duplicated.

Reset
REQ-024 On reset SHALL set tx=1, tx_active=0, tx_done=0, fifo_count=0, s_ready=1, FSM=IDLE, FIFO pointers=0; on the first cycle of reset, s_ready SHALL be 1 from the next edge.
REQ-025 Reset mid-frame SHALL abort the frame, flush buffered words, drive tx=1 from the next edge, and emit no tx_done.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, SHALL implement the PARITY state and honour parity_mode.
REQ-027 Without UART_TX_PARITY_EN, the parity_mode port SHALL remain present but be ignored, and no PARITY state or parity logic SHALL exist; every frame is start + DATA_BITS + STOP_BITS.

Structure
REQ-028 Package uart_pkg SHALL hold the FSM state enum (IDLE..STOP), the parity_mode encodings (PAR_NONE, PAR_EVEN, PAR_ODD), and the function computing the fifo_count width.
REQ-029 The buffer SHALL be a sub-module uart_tx_fifo: synchronous circular FIFO with push, pop, count, full and empty.

Verification
REQ-030 Defaults with CLKS_PER_BIT=4 and parity none: push 0xA5 -> tx stays low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4; tx_done pulses once; total frame is 40 cycles.
REQ-031 Parity (macro on): 0x07 with even parity -> parity bit 1; 0x07 with odd parity -> parity bit 0; frame is 44 cycles at CLKS_PER_BIT=4.
REQ-032 FIFO_DEPTH=4: hold s_valid high for 6 consecutive cycles from idle -> exactly 5 words accepted; s_ready goes low on the 6th cycle; 5 frames are output in order, each separated by a single idle cycle.
REQ-033 DATA_BITS=7, STOP_BITS=2, parity none, CLKS_PER_BIT=4 -> frame is 40 cycles with tx high during the final 8.
REQ-034 Assert reset for 1 cycle during data bit 3 with 2 words buffered -> tx=1, fifo_count=0, tx_active=0 from the next edge; no tx_done pulse; line stays idle afterwards.
REQ-035 Macro off: parity_mode=01 and push 0x07 -> frame has no parity bit and is 40 cycles at CLKS_PER_BIT=4.
